piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter: accepts N-bit words on a valid/ready

---
 rtl/piso_serializer.sv | 85 ++++++++
 tb/tb_piso_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes N-bit words on a valid/ready
// handshake and shifts them out one bit per clock with no gap between frames.
module piso_serializer #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         frame_done,
  output logic         busy
);

  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [N-1:0]   shreg, shreg_d;
  logic           last_bit;
  logic           accept;

  // The bit on the line is always the shift register's output end, so a
  // cleared register guarantees serial_out=0 whenever no frame is active.
  assign last_bit   = (state == SHIFT) && (cnt == '0);
  assign par_ready  = rst & ~abort & ((state == IDLE) | (cnt == '0));
  assign accept     = par_valid & par_ready;

  assign serial_out   = MSB_FIRST ? shreg[N-1] : shreg[0];
  assign serial_valid = (state == SHIFT);
  assign busy         = (state == SHIFT);
  assign frame_done   = last_bit;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (accept) begin
      state_d = SHIFT;
      cnt_d   = CW'(N - 1);
      shreg_d = par_data;
    end else if (state == SHIFT) begin
      if (cnt == '0) begin
        state_d = IDLE;
        shreg_d = '0;
      end else begin
        cnt_d   = cnt - 1'b1;
        shreg_d = MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      shreg <= shreg_d;
    end
  end

  // Structural invariants of the output decode.
  assert property (@(posedge clk) disable iff (!rst) frame_done |-> serial_valid);
  assert property (@(posedge clk) disable iff (!rst) !serial_valid |-> !serial_out);
  assert property (@(posedge clk) disable iff (!rst) busy == serial_valid);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: queue-based reference model checked every cycle,
// plus directed frames with hand-computed bit sequences.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, abort, par_valid;
  logic [3:0] par_data;
  logic       par_ready, serial_out, serial_valid, frame_done, busy;

  piso_serializer #(.N(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .abort(abort), .par_data(par_data), .par_valid(par_valid),
    .par_ready(par_ready), .serial_out(serial_out), .serial_valid(serial_valid),
    .frame_done(frame_done), .busy(busy)
  );

  logic       l_abort, l4_valid, l8_valid;
  logic [3:0] l4_data;
  logic [7:0] l8_data;
  logic       l4_ready, l4_out, l4_sv, l4_done, l4_busy;
  logic       l8_ready, l8_out, l8_sv, l8_done, l8_busy;

  piso_serializer #(.N(4), .MSB_FIRST(1'b0)) dut_l4 (
    .clk(clk), .rst(rst), .abort(l_abort), .par_data(l4_data), .par_valid(l4_valid),
    .par_ready(l4_ready), .serial_out(l4_out), .serial_valid(l4_sv),
    .frame_done(l4_done), .busy(l4_busy)
  );

  piso_serializer #(.N(8), .MSB_FIRST(1'b0)) dut_l8 (
    .clk(clk), .rst(rst), .abort(l_abort), .par_data(l8_data), .par_valid(l8_valid),
    .par_ready(l8_ready), .serial_out(l8_out), .serial_valid(l8_sv),
    .frame_done(l8_done), .busy(l8_busy)
  );

  // Four-stage siso chain fed by the main serializer.
  logic [3:0] siso_sr;
  logic       siso_out;
  always @(posedge clk or negedge rst) begin
    if (!rst) siso_sr <= '0;
    else      siso_sr <= {siso_sr[2:0], serial_out};
  end
  assign siso_out = siso_sr[3];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: the queue holds the bits still to appear on the line,
  // front element being the bit currently driven.
  bit mq[$];
  always @(negedge clk) begin
    if (!rst) mq.delete();
    check("model_valid", serial_valid, mq.size() != 0);
    check("model_busy",  busy,         mq.size() != 0);
    check("model_out",   serial_out,   (mq.size() != 0) ? mq[0] : 1'b0);
    check("model_done",  frame_done,   mq.size() == 1);
    check("model_ready", par_ready,    rst && !abort && (mq.size() <= 1));
    if (rst) begin
      if (abort) mq.delete();
      else if (par_valid && mq.size() <= 1) begin
        mq.delete();
        for (int i = 3; i >= 0; i--) mq.push_back(par_data[i]);
      end else if (mq.size() != 0) void'(mq.pop_front());
    end
  end

  initial begin
    logic [3:0] e2;
    logic [7:0] seq8, seq8b;
    logic [3:0] seq4;
    int         nd, nv, nd2;
    logic       dbits[12];
    logic       sbits[12];

    rst = 1'b0; abort = 1'b0; par_valid = 1'b1; par_data = 4'hF;
    l_abort = 1'b0; l4_valid = 1'b0; l8_valid = 1'b0; l4_data = '0; l8_data = '0;

    // Reset held with par_valid asserted.
    repeat (2) tick();
    #1;
    check("rst_ready", par_ready,    1'b0);
    check("rst_valid", serial_valid, 1'b0);
    check("rst_out",   serial_out,   1'b0);
    check("rst_busy",  busy,         1'b0);
    par_valid = 1'b0; rst = 1'b1;
    tick();
    check("rst_no_accept", serial_valid, 1'b0);

    // Single word, MSB first.
    e2 = 4'b1011;
    par_data = e2; par_valid = 1'b1;
    #1 check("t2_ready_idle", par_ready, 1'b1);
    tick();
    par_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_out",   serial_out,   e2[3-i]);
      check("t2_valid", serial_valid, 1'b1);
      check("t2_done",  frame_done,   i == 3);
      check("t2_ready", par_ready,    i == 3);
      tick();
    end
    check("t2_end_valid", serial_valid, 1'b0);

    // Back-to-back A then 5 with par_valid held.
    par_data = 4'hA; par_valid = 1'b1;
    tick();
    par_data = 4'h5;
    seq8 = '0; nd = 0; nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) par_valid = 1'b0;
      #1;
      seq8 = {seq8[6:0], serial_out};
      nd += int'(frame_done);
      nv += int'(serial_valid);
      tick();
    end
    check("t3_bits",  seq8, 8'hA5);
    check("t3_done",  nd, 2);
    check("t3_valid", nv, 8);
    check("t3_end_valid", serial_valid, 1'b0);

    // LSB-first instances: 4'b0001 on N=4, 8'hC3 on N=8.
    l4_data = 4'b0001; l8_data = 8'hC3; l4_valid = 1'b1; l8_valid = 1'b1;
    tick();
    l4_valid = 1'b0; l8_valid = 1'b0;
    seq4 = '0; seq8 = '0; nv = 0; nd = 0; nd2 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i < 4) seq4 = {seq4[2:0], l4_out};
      seq8 = {seq8[6:0], l8_out};
      nv  += int'(l4_sv);
      nd  += int'(l4_done);
      nd2 += int'(l8_done);
      tick();
    end
    check("t4_l4_bits",  seq4, 4'b1000);
    check("t4_l4_valid", nv, 4);
    check("t4_l4_done",  nd, 1);
    check("t4_l8_bits",  seq8, 8'b1100_0011);
    check("t4_l8_done",  nd2, 1);

    // Abort on the second bit, with a competing word offered.
    par_data = 4'hF; par_valid = 1'b1;
    tick();
    par_valid = 1'b0;
    tick();
    abort = 1'b1; par_valid = 1'b1; par_data = 4'h6;
    #1 check("t5_abort_ready", par_ready, 1'b0);
    tick();
    abort = 1'b0; par_valid = 1'b0;
    #1;
    check("t5_abort_valid", serial_valid, 1'b0);
    check("t5_abort_done",  frame_done,   1'b0);
    check("t5_abort_out",   serial_out,   1'b0);
    tick();
    check("t5_not_taken", serial_valid, 1'b0);

    // Reset pulsed on the third bit, then a fresh frame.
    par_data = 4'hF; par_valid = 1'b1;
    tick();
    par_valid = 1'b0;
    tick();
    tick();
    check("t5_pre_rst_valid", serial_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("t5_rst_valid", serial_valid, 1'b0);
    check("t5_rst_out",   serial_out,   1'b0);
    check("t5_rst_busy",  busy,         1'b0);
    check("t5_rst_ready", par_ready,    1'b0);
    tick();
    rst = 1'b1; par_data = 4'h9; par_valid = 1'b1;
    tick();
    par_valid = 1'b0;
    seq4 = '0;
    for (int i = 0; i < 4; i++) begin
      #1 seq4 = {seq4[2:0], serial_out};
      tick();
    end
    check("t5_fresh_bits", seq4, 4'h9);
    check("t5_fresh_end",  serial_valid, 1'b0);

    // Loopback through the siso chain: A then 3 back-to-back.
    par_data = 4'hA; par_valid = 1'b1;
    tick();
    par_data = 4'h3;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) par_valid = 1'b0;
      #1;
      dbits[i] = serial_out;
      sbits[i] = siso_out;
      tick();
    end
    seq8 = '0; seq8b = '0;
    for (int i = 0; i < 8; i++) begin
      seq8  = {seq8[6:0],  dbits[i]};
      seq8b = {seq8b[6:0], sbits[i+4]};
      check("t6_loop", sbits[i+4], dbits[i]);
    end
    check("t6_tx_bits",   seq8,  8'hA3);
    check("t6_siso_bits", seq8b, 8'hA3);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
